// File: rtl/mult_add5_feeder.sv
// Packs a serial (activation, weight) stream into five-pair bundles for the FC
// multiply-add datapath and re-times the datapath sum into a valid/last result stream.
module mult_add5_feeder #(
    parameter int OPERAND_WIDTH = 8,
    parameter int RESULT_WIDTH  = 2*OPERAND_WIDTH+3,
    parameter int DP_LATENCY    = 4
) (
    input  logic                          feed_clk,
    input  logic                          feed_rst,

    input  logic                          feed_in_valid_i,
    output logic                          feed_in_ready_o,
    input  logic [OPERAND_WIDTH-1:0]      feed_in_a_i,
    input  logic [OPERAND_WIDTH-1:0]      feed_in_b_i,
    input  logic                          feed_in_last_i,

    output logic [1:0][OPERAND_WIDTH-1:0] feed_dp_a_o,
    output logic [1:0][OPERAND_WIDTH-1:0] feed_dp_b_o,
    output logic [1:0][OPERAND_WIDTH-1:0] feed_dp_c_o,
    output logic [1:0][OPERAND_WIDTH-1:0] feed_dp_d_o,
    output logic [1:0][OPERAND_WIDTH-1:0] feed_dp_e_o,
    output logic                          feed_dp_issue_o,
    input  logic [RESULT_WIDTH-1:0]       feed_dp_result_i,

    output logic                          feed_out_valid_o,
    output logic [RESULT_WIDTH-1:0]       feed_out_data_o,
    output logic                          feed_out_last_o
);

    localparam int SLOTS = 5;

    // [0] = activation, [1] = weight, matching the datapath pair ports.
    typedef logic [1:0][OPERAND_WIDTH-1:0] pair_t;

    typedef struct packed {
        logic issue;
        logic last;
    } tag_t;

    logic                   ready_q;
    logic [2:0]             cnt_q;
    logic [2:0]             cnt_next;
    pair_t [SLOTS-1:0]      collect_q;
    pair_t [SLOTS-1:0]      collect_next;
    pair_t [SLOTS-1:0]      bundle;
    pair_t [SLOTS-1:0]      dp_q;
    logic                   issue_q;
    tag_t  [DP_LATENCY:0]   tag_q;
    tag_t                   tag_in;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic [RESULT_WIDTH-1:0] out_data_q;

    pair_t beat;
    logic  accept;
    logic  complete;

    assign beat     = {feed_in_b_i, feed_in_a_i};
    assign accept   = feed_in_valid_i && ready_q;
    assign complete = accept && ((cnt_q == 3'd4) || feed_in_last_i);

    // Bundle presented to the datapath: collected slots below cnt, the completing
    // beat at cnt, zero above it so an early-closed bundle adds nothing extra.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        bundle = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (3'(i) < cnt_q) begin
                bundle[i] = collect_q[i];
            end else if (3'(i) == cnt_q) begin
                bundle[i] = beat;
            end
        end
    end

    always_comb begin
        collect_next = collect_q;
        cnt_next     = cnt_q;
        if (complete) begin
            collect_next = '0;
            cnt_next     = 3'd0;
        end else if (accept) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (3'(i) == cnt_q) begin
                    collect_next[i] = beat;
                end
            end
            cnt_next = cnt_q + 3'd1;
        end
    end

    assign tag_in = '{issue: complete, last: complete && feed_in_last_i};

    // Collect side: counter, buffer and the one-cycle dp issue window.
    always_ff @(posedge feed_clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (feed_rst) begin
            // NOTE: the collect buffer is reset explicitly; a partial bundle must never leak past reset.
            ready_q   <= 1'b0;
            cnt_q     <= 3'd0;
            collect_q <= '0;
            dp_q      <= '0;
            issue_q   <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            cnt_q     <= cnt_next;
            collect_q <= collect_next;
            dp_q      <= complete ? bundle : '0;
            issue_q   <= complete;
        end
    end

    // Tag stage k holds the bundle completed k edges ago; stage DP_LATENCY lines up
    // with its sum arriving on feed_dp_result_i.
    always_ff @(posedge feed_clk) begin
        if (feed_rst) begin
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            tag_q       <= {tag_q[DP_LATENCY-1:0], tag_in};
            out_valid_q <= tag_q[DP_LATENCY].issue;
            out_last_q  <= tag_q[DP_LATENCY].issue && tag_q[DP_LATENCY].last;
            if (tag_q[DP_LATENCY].issue) begin
                out_data_q <= feed_dp_result_i;
            end
        end
    end

    assign feed_in_ready_o  = ready_q;
    assign feed_dp_a_o      = dp_q[0];
    assign feed_dp_b_o      = dp_q[1];
    assign feed_dp_c_o      = dp_q[2];
    assign feed_dp_d_o      = dp_q[3];
    assign feed_dp_e_o      = dp_q[4];
    assign feed_dp_issue_o  = issue_q;
    assign feed_out_valid_o = out_valid_q;
    assign feed_out_data_o  = out_data_q;
    assign feed_out_last_o  = out_last_q;

endmodule

// File: tb/tb_mult_add5_feeder.sv
// Directed bench for mult_add5_feeder with a behavioural DP_LATENCY-deep
// five-pair multiply-add datapath model driving feed_dp_result_i.
module tb_mult_add5_feeder;

    localparam int W  = 8;
    localparam int RW = 2*W+3;
    localparam int L  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [W-1:0]        in_a = '0;
    logic [W-1:0]        in_b = '0;
    logic                in_last = 1'b0;
    logic [1:0][W-1:0]   dp_a, dp_b, dp_c, dp_d, dp_e;
    logic                dp_issue;
    logic [RW-1:0]       dp_result;
    logic                out_valid;
    logic [RW-1:0]       out_data;
    logic                out_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_add5_feeder #(.OPERAND_WIDTH(W), .RESULT_WIDTH(RW), .DP_LATENCY(L)) dut (
        .feed_clk         (clk),
        .feed_rst         (rst),
        .feed_in_valid_i  (in_valid),
        .feed_in_ready_o  (in_ready),
        .feed_in_a_i      (in_a),
        .feed_in_b_i      (in_b),
        .feed_in_last_i   (in_last),
        .feed_dp_a_o      (dp_a),
        .feed_dp_b_o      (dp_b),
        .feed_dp_c_o      (dp_c),
        .feed_dp_d_o      (dp_d),
        .feed_dp_e_o      (dp_e),
        .feed_dp_issue_o  (dp_issue),
        .feed_dp_result_i (dp_result),
        .feed_out_valid_o (out_valid),
        .feed_out_data_o  (out_data),
        .feed_out_last_o  (out_last)
    );

    // Datapath model: sum of five products, delayed L cycles.
    function automatic logic [RW-1:0] pair_prod(input logic [1:0][W-1:0] p);
        return RW'(p[0]) * RW'(p[1]);
    endfunction

    logic [RW-1:0] pipe [L] = '{default: '0};
    always @(posedge clk) begin
        pipe[0] <= pair_prod(dp_a) + pair_prod(dp_b) + pair_prod(dp_c)
                 + pair_prod(dp_d) + pair_prod(dp_e);
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign dp_result = pipe[L-1];

    // Monitor, sampled on the falling edge.
    int            cyc = 0;
    int            n_pulses, n_issue, idle_nonzero, ready_drop;
    bit            ready_armed = 1'b0;
    int            p_data [8];
    bit            p_last [8];
    int            p_cyc  [8];
    logic [1:0][W-1:0] snap_b, snap_c, snap_d, snap_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            if (n_pulses < 8) begin
                p_data[n_pulses] = int'(out_data);
                p_last[n_pulses] = out_last;
                p_cyc[n_pulses]  = cyc;
            end
            n_pulses++;
        end
        if (dp_issue) begin
            n_issue++;
            snap_b = dp_b; snap_c = dp_c; snap_d = dp_d; snap_e = dp_e;
        end else if ((dp_a | dp_b | dp_c | dp_d | dp_e) != '0) begin
            idle_nonzero++;
        end
        if (ready_armed && !rst && !in_ready) ready_drop++;
    end

    int last_edge;

    task automatic clear_mon();
        n_pulses = 0; n_issue = 0; idle_nonzero = 0;
    endtask

    task automatic do_reset();
        ready_armed = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 ready_armed = 1'b1;
    endtask

    task automatic send(input int a, input int b, input bit last);
        in_valid = 1'b1;
        in_a = W'(a);
        in_b = W'(b);
        in_last = last;
        @(posedge clk);
        #1 last_edge = cyc;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        checks++;
        if ({out_valid, out_last, dp_issue} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {out_valid, out_last, dp_issue});
        end
        checks++;
        if (out_data !== '0 || (dp_a | dp_b | dp_c | dp_d | dp_e) !== '0) begin
            errors++; $display("FAIL reset_data: out_data=%0d want 0, dp nonzero", out_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
        @(posedge clk);
        #1 ready_armed = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b want 1", in_ready); end
    endtask

    task automatic test_full_bundle();
        clear_mon();
        for (int i = 0; i < 5; i++) send(2*i+1, 2*i+2, 1'b0);
        idle(12);
        checks++;
        if (n_issue !== 1) begin errors++; $display("FAIL full_issue_count: got %0d want 1", n_issue); end
        checks++;
        if (snap_e !== {8'd10, 8'd9}) begin errors++; $display("FAIL full_slot_e: got %h want 0a09", snap_e); end
        checks++;
        if (n_pulses !== 1) begin
            errors++; $display("FAIL full_pulses: got %0d want 1", n_pulses);
        end else begin
            checks++;
            if (p_data[0] !== 190 || p_last[0] !== 1'b0) begin
                errors++; $display("FAIL full_result: got %0d/%0b want 190/0", p_data[0], p_last[0]);
            end
            checks++;
            if (p_cyc[0] !== last_edge + L + 1) begin
                errors++; $display("FAIL full_latency: got edge %0d want %0d", p_cyc[0], last_edge + L + 1);
            end
        end
        checks++;
        if (out_data !== RW'(190)) begin errors++; $display("FAIL full_hold: got %0d want 190", out_data); end
        checks++;
        if (idle_nonzero !== 0) begin errors++; $display("FAIL full_idle_zero: got %0d want 0", idle_nonzero); end
    endtask

    task automatic test_early_last();
        clear_mon();
        send(255, 255, 1'b0);
        send(255, 255, 1'b1);
        idle(12);
        checks++;
        if (snap_b !== {8'd255, 8'd255} || (snap_c | snap_d | snap_e) !== '0) begin
            errors++; $display("FAIL early_slots: b=%h c=%h d=%h e=%h want ffff 0 0 0", snap_b, snap_c, snap_d, snap_e);
        end
        checks++;
        if (n_pulses !== 1) begin
            errors++; $display("FAIL early_pulses: got %0d want 1", n_pulses);
        end else begin
            checks++;
            if (p_data[0] !== 130050 || p_last[0] !== 1'b1) begin
                errors++; $display("FAIL early_result: got %0d/%0b want 130050/1", p_data[0], p_last[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        for (int i = 1; i <= 10; i++) send(i, 1, i == 10);
        idle(14);
        checks++;
        if (n_pulses !== 2) begin
            errors++; $display("FAIL b2b_pulses: got %0d want 2", n_pulses);
        end else begin
            checks++;
            if (p_data[0] !== 15 || p_last[0] !== 1'b0) begin
                errors++; $display("FAIL b2b_first: got %0d/%0b want 15/0", p_data[0], p_last[0]);
            end
            checks++;
            if (p_data[1] !== 40 || p_last[1] !== 1'b1) begin
                errors++; $display("FAIL b2b_second: got %0d/%0b want 40/1", p_data[1], p_last[1]);
            end
            checks++;
            if (p_cyc[1] - p_cyc[0] !== 5) begin
                errors++; $display("FAIL b2b_spacing: got %0d want 5", p_cyc[1] - p_cyc[0]);
            end
        end
        checks++;
        if (idle_nonzero !== 0) begin errors++; $display("FAIL b2b_idle_zero: got %0d want 0", idle_nonzero); end
    endtask

    task automatic test_gap();
        clear_mon();
        send(2, 3, 1'b0);
        send(2, 3, 1'b0);
        idle(3);
        send(2, 3, 1'b0);
        send(2, 3, 1'b0);
        idle(2);
        checks++;
        if (n_issue !== 0) begin errors++; $display("FAIL gap_early_issue: got %0d want 0", n_issue); end
        send(2, 3, 1'b0);
        idle(12);
        checks++;
        if (n_issue !== 1 || n_pulses !== 1) begin
            errors++; $display("FAIL gap_counts: issue=%0d pulses=%0d want 1 1", n_issue, n_pulses);
        end else begin
            checks++;
            if (p_data[0] !== 30) begin errors++; $display("FAIL gap_result: got %0d want 30", p_data[0]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int i = 0; i < 3; i++) send(7, 7, 1'b0);
        do_reset();
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL mid_reset_data: got %0d want 0", out_data); end
        for (int i = 0; i < 5; i++) send(3, 3, 1'b0);
        idle(1);
        do_reset();
        idle(12);
        checks++;
        if (n_pulses !== 0) begin errors++; $display("FAIL mid_no_pulse: got %0d want 0", n_pulses); end
        clear_mon();
        for (int i = 0; i < 5; i++) send(1, 1, 1'b0);
        idle(12);
        checks++;
        if (n_pulses !== 1) begin
            errors++; $display("FAIL mid_clean_pulses: got %0d want 1", n_pulses);
        end else begin
            checks++;
            if (p_data[0] !== 5 || p_last[0] !== 1'b0) begin
                errors++; $display("FAIL mid_clean_result: got %0d/%0b want 5/0", p_data[0], p_last[0]);
            end
        end
    endtask

    task automatic test_last_on_fifth();
        clear_mon();
        ready_drop = 0;
        for (int i = 0; i < 5; i++) send(1, 1, i == 4);
        idle(12);
        checks++;
        if (n_issue !== 1 || n_pulses !== 1) begin
            errors++; $display("FAIL fifth_counts: issue=%0d pulses=%0d want 1 1", n_issue, n_pulses);
        end else begin
            checks++;
            if (p_data[0] !== 5 || p_last[0] !== 1'b1) begin
                errors++; $display("FAIL fifth_result: got %0d/%0b want 5/1", p_data[0], p_last[0]);
            end
        end
        checks++;
        if (ready_drop !== 0) begin errors++; $display("FAIL ready_held: drops=%0d want 0", ready_drop); end
    endtask

    initial begin
        clear_mon();
        ready_drop = 0;
        test_reset();
        test_full_bundle();
        test_early_last();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_last_on_fifth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
